// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand capture, forwarding and load-use stall stage ahead of the ALU
module alu_operand_stage (
  input  logic        clk,
  input  logic        reset_n,
  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_ra,
  input  logic [3:0]  in_rb,
  input  logic [15:0] in_va,
  input  logic [15:0] in_vb,
  input  logic        in_use_b,
  input  logic [3:0]  in_dst,
  input  logic        in_wr,
  // execute/mem stage result
  input  logic        ex_wr,
  input  logic [3:0]  ex_dst,
  input  logic [15:0] ex_val,
  input  logic        ex_ld,
  // writeback stage result
  input  logic        wb_wr,
  input  logic [3:0]  wb_dst,
  input  logic [15:0] wb_val,
  // squash
  input  logic        flush,
  // ALU side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic [3:0]  out_dst,
  output logic        out_wr,
  output logic [15:0] stall_cnt
);

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_op_q,    out_op_d;
  logic [15:0] out_a_q,     out_a_d;
  logic [15:0] out_b_q,     out_b_d;
  logic [3:0]  out_dst_q,   out_dst_d;
  logic        out_wr_q,    out_wr_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        hazard;
  logic        space;
  logic        accept;
  logic        ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  logic [15:0] fwd_a, fwd_b;

  // Load-use hazard, free-slot detection and the combinational input handshake
  always_comb begin
    hazard   = in_valid & ex_wr & ex_ld &
               ((ex_dst == in_ra) | (in_use_b & (ex_dst == in_rb)));
    space    = ~out_valid_q | out_ready;
    // Hold off decode while reset is asserted so nothing is taken before the first clean edge
    in_ready = space & ~hazard & ~flush & reset_n;
    accept   = in_valid & in_ready;
  end

  // Bypass selection: the younger ex result wins over wb, a pending load never forwards
  always_comb begin
    ex_hit_a = ex_wr & ~ex_ld & (ex_dst == in_ra);
    wb_hit_a = wb_wr & (wb_dst == in_ra);
    ex_hit_b = in_use_b & ex_wr & ~ex_ld & (ex_dst == in_rb);
    wb_hit_b = in_use_b & wb_wr & (wb_dst == in_rb);

    if (ex_hit_a)      fwd_a = ex_val;
    else if (wb_hit_a) fwd_a = wb_val;
    else               fwd_a = in_va;

    if (ex_hit_b)      fwd_b = ex_val;
    else if (wb_hit_b) fwd_b = wb_val;
    else               fwd_b = in_vb;
  end

  // Next-state for the output slot: flush squashes, accept loads, a consumed slot drains
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_dst_d   = out_dst_q;
    out_wr_d    = out_wr_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_op_d    = in_op;
      out_a_d     = fwd_a;
      out_b_d     = fwd_b;
      out_dst_d   = in_dst;
      out_wr_d    = in_wr;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use hazards; backpressure is not counted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard & ~flush & (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_op_q    <= 4'h0;
      out_a_q     <= 16'h0000;
      out_b_q     <= 16'h0000;
      out_dst_q   <= 4'h0;
      out_wr_q    <= 1'b0;
      stall_cnt_q <= 16'h0000;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_dst_q   <= out_dst_d;
      out_wr_q    <= out_wr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_dst   = out_dst_q;
  assign out_wr    = out_wr_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Purpose: pipeline stage directly upstream of the ALU. It captures decoded ops, resolves operand forwarding and load-use hazards, and presents registered op/a/b to the ALU with a valid/ready handshake.

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock for all state.
REQ-002 reset_n input 1: asynchronous, active-low reset.
REQ-003 in_valid input 1: the decode stage presents an instruction.
REQ-004 in_ready output 1: the stage accepts the instruction this cycle.
REQ-005 in_op input 4: ALU opcode, same encoding as the ALU (0x0 NOT through 0xF SLTF).
REQ-006 in_ra, in_rb input 4 each: source register numbers.
REQ-007 in_va, in_vb input 16 each: register-file read values.
REQ-008 in_use_b input 1: the op reads operand b.
REQ-009 in_dst input 4 and in_wr input 1: destination register and write enable.
REQ-010 ex_wr input 1, ex_dst input 4, ex_val input 16, ex_ld input 1: the downstream ALU/mem stage result; ex_ld=1 means the value is not yet available.
REQ-011 wb_wr input 1, wb_dst input 4, wb_val input 16: writeback stage result.
REQ-012 flush input 1: squash the held instruction.
REQ-013 out_valid output 1, out_ready input 1: handshake toward the ALU stage.
REQ-014 out_op output 4, out_a output 16, out_b output 16, out_dst output 4, out_wr output 1: registered payload.
REQ-015 stall_cnt output 16: saturating count of hazard-stall cycles.

Function
REQ-016 hazard SHALL = in_valid & ex_wr & ex_ld & (ex_dst==in_ra | (in_use_b & ex_dst==in_rb)).
REQ-017 space SHALL = ~out_valid | out_ready.
REQ-018 in_ready SHALL = space & ~hazard & ~flush, combinationally.
REQ-019 Operand a SHALL forward with priority: ex_val if ex_wr & ~ex_ld & ex_dst==in_ra; else wb_val if wb_wr & wb_dst==in_ra; else in_va.
REQ-020 Operand b SHALL use the same rule on in_rb and in_vb; when in_use_b=0, b SHALL be in_vb unmodified.
REQ-021 Accept SHALL occur when in_valid & in_ready; on the next edge all payload registers load and out_valid<=1, so latency is 1 cycle.
REQ-022 When out_valid & out_ready and no accept occurs, out_valid SHALL clear on the next edge.
REQ-023 While out_valid & ~out_ready, the payload SHALL hold stable; forwarding is evaluated only at capture.
REQ-024 flush SHALL take priority: next edge out_valid<=0, no accept; the payload may keep stale values.
REQ-025 Each cycle with hazard=1 and flush=0, stall_cnt SHALL increment, saturating at 0xFFFF; backpressure-only stalls SHALL NOT count.
REQ-026 out_valid=0 SHALL force the ALU consumer to ignore the payload; the payload has no meaning when invalid.
REQ-027 Simultaneous ex and wb match on the same register SHALL select ex_val.
REQ-028 in_ra==in_rb SHALL give identical forwarded a and b.

Reset
REQ-029 reset_n=0 SHALL immediately clear out_valid, out_op, out_a, out_b, out_dst, out_wr and stall_cnt to 0, independent of clk.
REQ-030 in_ready SHALL be 0 while reset_n=0; after deassertion, the first accept is possible on the first clk edge.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction with no output handshake.

Verification
REQ-032 Set in_op=6, ra=1, rb=2, va=0x0003, vb=0x0004, use_b=1, out_ready=1, no forwards -> the next cycle gives out_valid=1, out_a=0x0003, out_b=0x0004, out_op=6.
REQ-033 Set ex_wr=1, ex_dst=1, ex_val=0x1111, wb_wr=1, wb_dst=1, wb_val=0x2222, ra=1 -> out_a=0x1111; with ex_wr=0 -> out_a=0x2222.
REQ-034 Set ex_ld=1, ex_wr=1, ex_dst=2, in_rb=2, use_b=1 for 3 cycles -> in_ready=0 for 3 cycles and stall_cnt=3; clear ex_ld -> accept, out_b=ex_val.
REQ-035 Hold out_ready=0 with out_valid=1 -> in_ready=0 and the payload unchanged for 5 cycles while stall_cnt is unchanged; raise out_ready -> pipelined accept with no bubble.
REQ-036 Assert flush with out_valid=1 -> out_valid=0 the next cycle and in_ready=0 during flush; pulse reset_n low between edges -> all outputs are 0 immediately.
REQ-037 Preload stall_cnt to 0xFFFE via 3 hazard cycles -> the count reads 0xFFFF and holds.
